// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor UART baud generator: oversample tick, 1x bit tick, glitch-free
// divisor updates through a shadow register, plus enable and phase resync.
module uart_baud_gen_frac #(
  parameter int CLK_RATE   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  localparam int PHASE_W   = $clog2(OVERSAMPLE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  resync,
  input  logic [INT_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_wr,
  output logic                  tick,
  output logic                  bit_tick,
  output logic [PHASE_W-1:0]    os_phase,
  output logic                  div_pending,
  output logic                  div_rej
);

  // Reset divisor in units of 1/2^FRAC_WIDTH cycle, rounded to nearest.
  localparam longint DEF_Q =
    (longint'(CLK_RATE) * (longint'(1) << FRAC_WIDTH) + longint'(BAUD_RATE) * OVERSAMPLE / 2)
    / (longint'(BAUD_RATE) * OVERSAMPLE);
  localparam logic [INT_WIDTH-1:0]  DEF_INT    = INT_WIDTH'(DEF_Q >> FRAC_WIDTH);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC   = FRAC_WIDTH'(DEF_Q);
  localparam logic [PHASE_W-1:0]    PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

  logic [INT_WIDTH-1:0]  a_int, s_int;
  logic [FRAC_WIDTH-1:0] a_frac, s_frac;
  logic [INT_WIDTH:0]    cnt;
  logic [FRAC_WIDTH-1:0] acc;
  logic                  ext;

  logic [INT_WIDTH:0]    lim;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic                  apply;
  logic                  wr_ok;

  // NOTE: every output of this block gets a value on every path, so no latches are inferred.
  always_comb begin
    lim      = {1'b0, a_int} + {{INT_WIDTH{1'b0}}, ext};
    frac_sum = {1'b0, acc} + {1'b0, a_frac};
    // A divisor applied while paused can leave cnt beyond the new limit; >= keeps it from wrapping.
    tick     = !rst && en && !resync && (cnt >= lim - (INT_WIDTH + 1)'(1));
    bit_tick = tick && (os_phase == PHASE_LAST);
    apply    = div_pending && (tick || resync || !en);
    wr_ok    = div_wr && (div_int != '0);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_int       <= DEF_INT;
      a_frac      <= DEF_FRAC;
      s_int       <= DEF_INT;
      s_frac      <= DEF_FRAC;
      cnt         <= '0;
      acc         <= '0;
      ext         <= 1'b0;
      os_phase    <= '0;
      div_pending <= 1'b0;
      div_rej     <= 1'b0;
    end else begin
      div_rej <= div_wr && (div_int == '0);

      if (resync) begin
        cnt      <= '0;
        acc      <= '0;
        ext      <= 1'b0;
        os_phase <= '0;
      end else if (tick) begin
        cnt      <= '0;
        acc      <= frac_sum[FRAC_WIDTH-1:0];
        ext      <= frac_sum[FRAC_WIDTH];
        os_phase <= (os_phase == PHASE_LAST) ? '0 : os_phase + PHASE_W'(1);
      end else if (en) begin
        cnt <= cnt + (INT_WIDTH + 1)'(1);
      end

      // The period ending now keeps the old divisor; the new one starts from a clean fraction.
      if (apply) begin
        a_int  <= s_int;
        a_frac <= s_frac;
        acc    <= '0;
        ext    <= 1'b0;
      end

      // A write coinciding with an apply lands in the shadow and waits for the next apply.
      if (wr_ok) begin
        s_int       <= div_int;
        s_frac      <= div_frac;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end
    end
  end

endmodule
